// File: rtl/serializer12bit_tx_if.sv
// Handshake and serial-line bundle for the word serializer.
interface serializer12bit_tx_if #(
   parameter int WIDTH = 12
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_en;
   logic             done;
   logic             busy;

   modport master (
      output data_in, load_valid,
      input  load_ready, ser_out, ser_en, done, busy
   );

   modport slave (
      input  data_in, load_valid,
      output load_ready, ser_out, ser_en, done, busy
   );
endinterface

// File: rtl/serializer12bit_tx.sv
// Parallel-in serial-out transmitter: one word per frame,
// one bit per clock, qualified by ser_en, done after last bit.
module serializer12bit_tx #(
   parameter int WIDTH     = 12,
   parameter int MSB_FIRST = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   serializer12bit_tx_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_en_q, ser_en_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;

   // The shift register holds the bits not yet on the line,
   // so the head bit is always at the same end.
   function automatic logic head(input logic [WIDTH-1:0] x);
      return (MSB_FIRST != 0) ? x[WIDTH-1] : x[0];
   endfunction

   function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] x);
      return (MSB_FIRST != 0) ? {x[WIDTH-2:0], 1'b0}
                              : {1'b0, x[WIDTH-1:1]};
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      ser_out_d = 1'b0;
      ser_en_d  = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      ready_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (bus.load_valid && ready_q) begin
               state_d   = S_SHIFT;
               cnt_d     = '0;
               sh_d      = adv(bus.data_in);
               ser_out_d = head(bus.data_in);
               ser_en_d  = 1'b1;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
            end
         end
         S_SHIFT: begin
            busy_d = 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d     = cnt_q + CW'(1);
               ser_out_d = head(sh_q);
               sh_d      = adv(sh_q);
               ser_en_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         ser_out_q <= 1'b0;
         ser_en_q  <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         ser_out_q <= ser_out_d;
         ser_en_q  <= ser_en_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.load_ready = ready_q;
   assign bus.ser_out    = ser_out_q;
   assign bus.ser_en     = ser_en_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_serializer12bit_tx.sv
// Directed bench: MSB-first and LSB-first serializers side by side.
module tb_serializer12bit_tx;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   serializer12bit_tx_if #(.WIDTH(12)) m_if ();
   serializer12bit_tx_if #(.WIDTH(12)) l_if ();

   serializer12bit_tx #(.WIDTH(12), .MSB_FIRST(1)) u_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if.slave)
   );

   serializer12bit_tx #(.WIDTH(12), .MSB_FIRST(0)) u_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (l_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          lsb;
      logic [11:0] d;
      logic [11:0] exp;
      string       nm;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic drive(input bit lsb, input logic v, input logic [11:0] d);
      if (lsb) begin
         l_if.load_valid = v;
         l_if.data_in    = d;
      end else begin
         m_if.load_valid = v;
         m_if.data_in    = d;
      end
   endtask

   // {ser_en, ser_out, done, busy, load_ready}
   function automatic logic [4:0] outs(input bit lsb);
      if (lsb)
         return {l_if.ser_en, l_if.ser_out, l_if.done, l_if.busy, l_if.load_ready};
      return {m_if.ser_en, m_if.ser_out, m_if.done, m_if.busy, m_if.load_ready};
   endfunction

   // Sends one word; optionally pokes a rejected word at bit cycle poke.
   task automatic run_frame(input bit lsb, input logic [11:0] d,
                            input logic [11:0] exp, input string nm,
                            input int poke, input logic [11:0] poke_d);
      logic [11:0] seq;
      logic [4:0]  o;
      seq = '0;
      @(negedge clk);
      chk({nm, "_ready_before"}, 32'(outs(lsb)), 32'(5'b00001));
      drive(lsb, 1'b1, d);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (lsb) l_if.load_valid = 1'b0;
         else     m_if.load_valid = 1'b0;
         o   = outs(lsb);
         seq = {seq[10:0], o[3]};
         chk({nm, "_bitcyc"}, 32'({o[4], o[2:0]}), 32'(4'b1010));
         if (i == poke) drive(lsb, 1'b1, poke_d);
      end
      chk({nm, "_seq"}, 32'(seq), 32'(exp));
      @(negedge clk);
      if (lsb) l_if.load_valid = 1'b0;
      else     m_if.load_valid = 1'b0;
      chk({nm, "_done"}, 32'(outs(lsb)), 32'(5'b00110));
      @(negedge clk);
      chk({nm, "_idle_after"}, 32'(outs(lsb)), 32'(5'b00001));
   endtask

   initial begin
      logic [11:0] seq1, seq2;
      logic [4:0]  o;
      logic        prev;
      int          st1, st2, nf;

      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);

      tbl[0] = '{0, 12'h0A0, 12'h0A0, "msb_160"};
      tbl[1] = '{0, 12'h0FA, 12'h0FA, "msb_250"};
      tbl[2] = '{0, 12'h036, 12'h036, "msb_54"};
      tbl[3] = '{0, 12'h000, 12'h000, "msb_zero"};
      tbl[4] = '{0, 12'hFFF, 12'hFFF, "msb_ones"};
      tbl[5] = '{1, 12'h036, 12'h6C0, "lsb_54"};
      tbl[6] = '{1, 12'h0A0, 12'h050, "lsb_160"};
      tbl[7] = '{1, 12'h801, 12'h801, "lsb_801"};

      // reset then idle
      repeat (3) @(negedge clk);
      chk("rst_msb", 32'(outs(0)), 32'(5'b00001));
      chk("rst_lsb", 32'(outs(1)), 32'(5'b00001));
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_msb", 32'(outs(0)), 32'(5'b00001));
         chk("idle_lsb", 32'(outs(1)), 32'(5'b00001));
      end

      foreach (tbl[k])
         run_frame(tbl[k].lsb, tbl[k].d, tbl[k].exp, tbl[k].nm, -1, '0);

      // busy rejection: 54 offered mid-frame must be dropped
      run_frame(0, 12'h0FA, 12'h0FA, "busy_rej", 4, 12'h036);
      @(negedge clk);
      chk("busy_rej_noframe", 32'(outs(0)), 32'(5'b00001));

      // back-to-back with load_valid held high
      @(negedge clk);
      drive(0, 1'b1, 12'h0FA);
      st1 = -1; st2 = -1; nf = 0; prev = 1'b0;
      seq1 = '0; seq2 = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) m_if.data_in = 12'h036;
         o = outs(0);
         if (o[4] && !prev) begin
            nf++;
            if (nf == 1) st1 = c;
            else if (nf == 2) begin
               st2 = c;
               drive(0, 1'b0, 12'h036);
            end
         end
         if (o[4] && nf == 1) seq1 = {seq1[10:0], o[3]};
         if (o[4] && nf == 2) seq2 = {seq2[10:0], o[3]};
         prev = o[4];
      end
      chk("b2b_frames", 32'(nf), 32'd2);
      chk("b2b_start1", 32'(st1), 32'd1);
      chk("b2b_spacing", 32'(st2 - st1), 32'd14);
      chk("b2b_seq1", 32'(seq1), 32'h0FA);
      chk("b2b_seq2", 32'(seq2), 32'h036);

      // async reset mid-frame
      @(negedge clk);
      drive(0, 1'b1, 12'h0A0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         m_if.load_valid = 1'b0;
      end
      chk("midrst_active", 32'(outs(0) & 5'b10011), 32'(5'b10010));
      #2 rst_n = 1'b0;
      #1 chk("midrst_async", 32'(outs(0)), 32'(5'b00001));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_hold", 32'(outs(0)), 32'(5'b00001));
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_nodone", 32'(outs(0)), 32'(5'b00001));
      run_frame(0, 12'h036, 12'h036, "post_rst", -1, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
